// File: rtl/lcd_timing_gen_if.sv
// Panel-side bundle of the LCD timing generator: run enable in, raster
// timing and pixel-request strobes out.
interface lcd_timing_gen_if;
    logic       en;
    logic       disp_clk;
    logic       disp_hsync;
    logic       disp_vsync;
    logic       disp_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pixel_req;
    logic       frame_start;

    // master: the timing generator; slave: the colour logic / panel side
    modport master (
        input  en,
        output disp_clk, disp_hsync, disp_vsync, disp_en,
        output pixel_x, pixel_y, pixel_req, frame_start
    );
    modport slave (
        output en,
        input  disp_clk, disp_hsync, disp_vsync, disp_en,
        input  pixel_x, pixel_y, pixel_req, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a 480x272 RGB LCD. Divides clk into the pixel
// clock, walks horizontal/vertical counters through active, front porch, sync
// and back porch, and drives registered sync/enable, pixel coordinates and
// per-pixel request strobes. Every output is computed from the counter values
// being loaded in the same edge, so the outputs for a pixel period appear in
// the clk where div_cnt becomes 0 and stay stable until the next period.
// A pixel_req..frame_start handshake has no back-pressure: the consumer must
// have RGB ready before the disp_clk rising edge, CLK_DIV/2 clks later.
module lcd_timing_gen #(
    parameter int CLK_DIV  = 5,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BACK   = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BACK   = 2
) (
    input logic              clk,
    input logic              reset_n,
    lcd_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0]       H_SYN_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0]       H_SYN_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]       V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]       V_SYN_BEG = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]       V_SYN_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // Reject parameter sets the divider or 10-bit coordinates cannot represent
    if (CLK_DIV < 2) begin : g_bad_div
        $error("lcd_timing_gen: CLK_DIV must be at least 2");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("lcd_timing_gen: H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    // Low after reset or idle: the next enabled edge starts at pixel (0,0)
    // rather than advancing past it.
    logic             running;

    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             h_act_nxt;
    logic             v_act_nxt;
    logic             h_syn_nxt;
    logic             v_syn_nxt;
    logic             period_start;

    logic             disp_clk_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             disp_en_q;
    logic [9:0]       pixel_x_q;
    logic [9:0]       pixel_y_q;
    logic             pixel_req_q;
    logic             frame_start_q;

    // Next counter values and their region decode
    always_comb begin
        div_nxt = '0;
        h_nxt   = '0;
        v_nxt   = '0;
        if (running) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                h_nxt   = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
                if (h_cnt == H_LAST) begin
                    v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    v_nxt = v_cnt;
                end
            end else begin
                div_nxt = div_cnt + DIV_W'(1);
                h_nxt   = h_cnt;
                v_nxt   = v_cnt;
            end
        end
        h_act_nxt    = (h_nxt < H_ACT_END);
        v_act_nxt    = (v_nxt < V_ACT_END);
        h_syn_nxt    = (h_nxt >= H_SYN_BEG) && (h_nxt < H_SYN_END);
        v_syn_nxt    = (v_nxt >= V_SYN_BEG) && (v_nxt < V_SYN_END);
        period_start = (div_nxt == '0);
    end

    // Counters and registered outputs; en low is a synchronous idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt       <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            running       <= 1'b0;
            disp_clk_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            disp_en_q     <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_req_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (!bus.en) begin
            div_cnt       <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            running       <= 1'b0;
            disp_clk_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            disp_en_q     <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_req_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt       <= div_nxt;
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            running       <= 1'b1;
            disp_clk_q    <= (div_nxt >= DIV_HALF);
            hsync_q       <= ~h_syn_nxt;
            vsync_q       <= ~v_syn_nxt;
            disp_en_q     <= h_act_nxt && v_act_nxt;
            if (h_act_nxt && v_act_nxt) begin
                pixel_x_q <= h_nxt;
                pixel_y_q <= v_nxt;
            end
            pixel_req_q   <= period_start && h_act_nxt && v_act_nxt;
            frame_start_q <= period_start && (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign bus.disp_clk    = disp_clk_q;
    assign bus.disp_hsync  = hsync_q;
    assign bus.disp_vsync  = vsync_q;
    assign bus.disp_en     = disp_en_q;
    assign bus.pixel_x     = pixel_x_q;
    assign bus.pixel_y     = pixel_y_q;
    assign bus.pixel_req   = pixel_req_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a default-size instance for line-level timing and
// a small CLK_DIV=2 instance for frame-level and mid-vsync reset behaviour.
module tb_lcd_timing_gen;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_chk;
    int   n_fail;

    lcd_timing_gen_if bus_a ();
    lcd_timing_gen_if bus_b ();

    lcd_timing_gen dut_a (
        .clk     (clk),
        .reset_n (rst_a),
        .bus     (bus_a)
    );

    // 15 pixels x 8 lines, 2 clks per pixel: frame = 240 clks
    lcd_timing_gen #(
        .CLK_DIV (2),
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_b (
        .clk     (clk),
        .reset_n (rst_b),
        .bus     (bus_b)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       dclk;
        logic       req;
        logic       fs;
        logic       den;
        logic       hs;
        logic       vs;
        logic [9:0] px;
        logic [9:0] py;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx, input logic dclk, input logic hs,
                                  input logic vs, input logic den, input logic req,
                                  input logic fs, input logic [9:0] px, input logic [9:0] py);
        chk({pfx, " disp_clk"}, int'(dclk), 0);
        chk({pfx, " hsync"}, int'(hs), 1);
        chk({pfx, " vsync"}, int'(vs), 1);
        chk({pfx, " disp_en"}, int'(den), 0);
        chk({pfx, " pixel_req"}, int'(req), 0);
        chk({pfx, " frame_start"}, int'(fs), 0);
        chk({pfx, " pixel_x"}, int'(px), 0);
        chk({pfx, " pixel_y"}, int'(py), 0);
    endtask

    // Entered with the frame_start sample of dut_b current; leaves with the
    // next frame_start sample current.
    task automatic run_small_frame(input string pfx);
        int req_cnt, fs_cnt, vs_low, vs_first, dclk_err, req_odd, py_bad;
        req_cnt = 0; fs_cnt = 0; vs_low = 0; vs_first = -1;
        dclk_err = 0; req_odd = 0; py_bad = 0;
        for (int k = 0; k < 240; k++) begin
            if (k > 0) tick();
            if (bus_b.pixel_req) begin
                req_cnt++;
                if ((k % 2) != 0) req_odd++;
            end
            if (bus_b.frame_start) fs_cnt++;
            if (bus_b.disp_clk !== ((k % 2) == 1)) dclk_err++;
            if (bus_b.disp_en && bus_b.pixel_y > 10'd3) py_bad++;
            if (!bus_b.disp_vsync) begin
                if (vs_first < 0) vs_first = k;
                vs_low++;
            end
        end
        tick();
        chk({pfx, " pixel_req count"}, req_cnt, 32);
        chk({pfx, " frame_start count"}, fs_cnt, 1);
        chk({pfx, " vsync low clks"}, vs_low, 60);
        chk({pfx, " vsync start"}, vs_first, 150);
        chk({pfx, " disp_clk toggle errors"}, dclk_err, 0);
        chk({pfx, " pixel_req odd-clk"}, req_odd, 0);
        chk({pfx, " pixel_y beyond active"}, py_bad, 0);
        chk({pfx, " frame_start at 240"}, int'(bus_b.frame_start), 1);
    endtask

    initial begin
        int cur;
        int req_cnt, px_err, hs_low, hs_first;
        n_chk  = 0;
        n_fail = 0;

        //               idx  dclk req fs den hs vs px   py
        vecs[0]  = '{    0,   0,   1,  1, 1,  1, 1, 0,   0};
        vecs[1]  = '{    1,   0,   0,  0, 1,  1, 1, 0,   0};
        vecs[2]  = '{    2,   1,   0,  0, 1,  1, 1, 0,   0};
        vecs[3]  = '{    4,   1,   0,  0, 1,  1, 1, 0,   0};
        vecs[4]  = '{    5,   0,   1,  0, 1,  1, 1, 1,   0};
        vecs[5]  = '{    7,   1,   0,  0, 1,  1, 1, 1,   0};
        vecs[6]  = '{ 2395,   0,   1,  0, 1,  1, 1, 479, 0};
        vecs[7]  = '{ 2399,   1,   0,  0, 1,  1, 1, 479, 0};
        vecs[8]  = '{ 2400,   0,   0,  0, 0,  1, 1, 479, 0};
        vecs[9]  = '{ 2410,   0,   0,  0, 0,  0, 1, 479, 0};
        vecs[10] = '{ 2614,   1,   0,  0, 0,  0, 1, 479, 0};
        vecs[11] = '{ 2615,   0,   0,  0, 0,  1, 1, 479, 0};
        vecs[12] = '{ 2625,   0,   1,  0, 1,  1, 1, 0,   1};

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.en = 1'b1;
        bus_b.en = 1'b1;
        repeat (3) tick();
        chk_reset_vals("a reset", bus_a.disp_clk, bus_a.disp_hsync, bus_a.disp_vsync,
                       bus_a.disp_en, bus_a.pixel_req, bus_a.frame_start,
                       bus_a.pixel_x, bus_a.pixel_y);

        // release with en high: idx 0 is the first sampled clk
        rst_a = 1'b1;
        tick();
        cur = 0;
        foreach (vecs[i]) begin
            while (cur < vecs[i].idx) begin
                tick();
                cur++;
            end
            chk($sformatf("v%0d disp_clk", vecs[i].idx), int'(bus_a.disp_clk), int'(vecs[i].dclk));
            chk($sformatf("v%0d pixel_req", vecs[i].idx), int'(bus_a.pixel_req), int'(vecs[i].req));
            chk($sformatf("v%0d frame_start", vecs[i].idx), int'(bus_a.frame_start), int'(vecs[i].fs));
            chk($sformatf("v%0d disp_en", vecs[i].idx), int'(bus_a.disp_en), int'(vecs[i].den));
            chk($sformatf("v%0d hsync", vecs[i].idx), int'(bus_a.disp_hsync), int'(vecs[i].hs));
            chk($sformatf("v%0d vsync", vecs[i].idx), int'(bus_a.disp_vsync), int'(vecs[i].vs));
            chk($sformatf("v%0d pixel_x", vecs[i].idx), int'(bus_a.pixel_x), int'(vecs[i].px));
            chk($sformatf("v%0d pixel_y", vecs[i].idx), int'(bus_a.pixel_y), int'(vecs[i].py));
        end

        // one full line (line 1), starting at its first pixel_req
        req_cnt = 0; px_err = 0; hs_low = 0; hs_first = -1;
        for (int k = 0; k < 2625; k++) begin
            if (k > 0) tick();
            if (bus_a.pixel_req) begin
                if (bus_a.pixel_x !== 10'(req_cnt) || bus_a.pixel_y !== 10'd1) px_err++;
                req_cnt++;
            end
            if (!bus_a.disp_hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_low++;
            end
        end
        tick();
        chk("line pixel_req count", req_cnt, 480);
        chk("line pixel_x order errors", px_err, 0);
        chk("line hsync low clks", hs_low, 205);
        chk("line hsync start", hs_first, 2410);
        chk("line period pixel_req", int'(bus_a.pixel_req), 1);
        chk("line period pixel_y", int'(bus_a.pixel_y), 2);

        // drop en at line 2 pixel 250
        repeat (1250) tick();
        chk("pixel 250 pixel_x", int'(bus_a.pixel_x), 250);
        chk("pixel 250 pixel_req", int'(bus_a.pixel_req), 1);
        bus_a.en = 1'b0;
        tick();
        chk_reset_vals("en drop", bus_a.disp_clk, bus_a.disp_hsync, bus_a.disp_vsync,
                       bus_a.disp_en, bus_a.pixel_req, bus_a.frame_start,
                       bus_a.pixel_x, bus_a.pixel_y);
        repeat (3) tick();
        bus_a.en = 1'b1;
        tick();
        chk("en rise frame_start", int'(bus_a.frame_start), 1);
        chk("en rise pixel_req", int'(bus_a.pixel_req), 1);
        chk("en rise disp_en", int'(bus_a.disp_en), 1);
        chk("en rise pixel_x", int'(bus_a.pixel_x), 0);
        chk("en rise pixel_y", int'(bus_a.pixel_y), 0);
        repeat (2625) tick();
        chk("en rise full line pixel_y", int'(bus_a.pixel_y), 1);
        chk("en rise full line pixel_x", int'(bus_a.pixel_x), 0);
        chk("en rise full line pixel_req", int'(bus_a.pixel_req), 1);

        // small CLK_DIV=2 instance: whole frame
        rst_b = 1'b1;
        tick();
        chk("small first frame_start", int'(bus_b.frame_start), 1);
        run_small_frame("small frame");

        // asynchronous reset in the middle of vsync
        repeat (160) tick();
        chk("mid-vsync vsync low", int'(bus_b.disp_vsync), 0);
        rst_b = 1'b0;
        #1;
        chk("async reset vsync", int'(bus_b.disp_vsync), 1);
        chk("async reset disp_clk", int'(bus_b.disp_clk), 0);
        chk("async reset disp_en", int'(bus_b.disp_en), 0);
        rst_b = 1'b1;
        tick();
        chk("post reset frame_start", int'(bus_b.frame_start), 1);
        chk("post reset pixel_req", int'(bus_b.pixel_req), 1);
        run_small_frame("post reset frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
